// File: rtl/multi_ch_clk_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel request FSM with wake-up
// delay and programmable idle hysteresis, driving a latch-based glitch-free gate.

module clk_gate_ch #(
  parameter int IDLE_CNT_W = 4,
  parameter int WAKE_DLY   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  test_en,
  input  logic                  want,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  output logic                  gclk,
  output logic                  en_q,
  output logic                  ready_q
);
  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_HOLD} st_t;

  localparam logic [2:0] WAKE_INIT = 3'(WAKE_DLY);

  st_t                   state, state_nxt;
  logic [2:0]            wake_cnt, wake_nxt;
  logic [IDLE_CNT_W-1:0] idle_cnt, idle_nxt;
  logic [IDLE_CNT_W:0]   idle_inc;
  logic                  en_d, rdy_d, lat_q;

  assign idle_inc = {1'b0, idle_cnt} + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_OFF;
      wake_cnt <= '0;
      idle_cnt <= '0;
      en_q     <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wake_cnt <= wake_nxt;
      idle_cnt <= idle_nxt;
      en_q     <= en_d;
      ready_q  <= rdy_d;
    end
  end

  // want wins over the threshold in HOLD; a started wake always completes
  always_comb begin
    state_nxt = state;
    wake_nxt  = wake_cnt;
    idle_nxt  = idle_cnt;
    case (state)
      S_OFF: if (want) begin
        state_nxt = S_WAKE;
        wake_nxt  = WAKE_INIT;
      end
      S_WAKE: if (wake_cnt <= 3'd1) begin
        state_nxt = S_ON;
        wake_nxt  = '0;
      end else begin
        wake_nxt  = wake_cnt - 3'd1;
      end
      S_ON: if (!want) begin
        state_nxt = (idle_thresh == '0) ? S_OFF : S_HOLD;
        idle_nxt  = '0;
      end
      S_HOLD: if (want) begin
        state_nxt = S_ON;
        idle_nxt  = '0;
      end else if (idle_inc >= {1'b0, idle_thresh}) begin
        state_nxt = S_OFF;
        idle_nxt  = '0;
      end else begin
        idle_nxt  = (&idle_cnt) ? idle_cnt : idle_inc[IDLE_CNT_W-1:0];
      end
      default: state_nxt = S_OFF;
    endcase
  end

  // outputs are decoded from the next state and registered alongside it
  always_comb begin
    en_d  = (state_nxt != S_OFF);
    rdy_d = (state_nxt == S_ON) || (state_nxt == S_HOLD);
  end

  always_latch begin
    if (!rst_n)   lat_q <= 1'b0;
    else if (!clk) lat_q <= en_q | test_en;
  end

  assign gclk = clk & lat_q;
endmodule

module multi_ch_clk_gate_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int IDLE_CNT_W = 4,
  parameter int WAKE_DLY   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  test_en,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [NUM_CH-1:0]     ch_force_on,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  output logic [NUM_CH-1:0]     gclk,
  output logic [NUM_CH-1:0]     ch_active,
  output logic [NUM_CH-1:0]     ch_ready
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gate_ch #(
      .IDLE_CNT_W (IDLE_CNT_W),
      .WAKE_DLY   (WAKE_DLY)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .test_en     (test_en),
      .want        (ch_req[i] | ch_force_on[i]),
      .idle_thresh (idle_thresh),
      .gclk        (gclk[i]),
      .en_q        (ch_active[i]),
      .ready_q     (ch_ready[i])
    );
  end
endmodule

// File: tb/tb_multi_ch_clk_gate_ctrl.sv
// Directed vector bench for multi_ch_clk_gate_ctrl (NUM_CH=4, WAKE_DLY=2).

module tb_multi_ch_clk_gate_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       test_en;
  logic [3:0] ch_req, ch_force_on, idle_thresh;
  logic [3:0] gclk, ch_active, ch_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req, frc, thr;
    logic       ten;
    logic [3:0] act, rdy, g;
  } vec_t;

  vec_t vt[$];

  multi_ch_clk_gate_ctrl #(.NUM_CH(4), .IDLE_CNT_W(4), .WAKE_DLY(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .test_en     (test_en),
    .ch_req      (ch_req),
    .ch_force_on (ch_force_on),
    .idle_thresh (idle_thresh),
    .gclk        (gclk),
    .ch_active   (ch_active),
    .ch_ready    (ch_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got=%b expected=%b", name, idx, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] a, input logic [3:0] r, input logic [3:0] g);
    chk({tag, ".active"}, idx, ch_active, a);
    chk({tag, ".ready"},  idx, ch_ready,  r);
    chk({tag, ".gclk"},   idx, gclk,      g);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] frc, input logic [3:0] thr, input logic ten,
                     input logic [3:0] act, input logic [3:0] rdy, input logic [3:0] g);
    vec_t v;
    v.req = req; v.frc = frc; v.thr = thr; v.ten = ten;
    v.act = act; v.rdy = rdy; v.g = g;
    vt.push_back(v);
  endtask

  initial begin
    // Each row: inputs sampled at the next edge, outputs checked just after it.
    // ch0 request then release with thresh=3
    add(4'b0001, 4'b0000, 4'd3, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'd3, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    add(4'b0001, 4'b0000, 4'd3, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add(4'b0000, 4'b0000, 4'd3, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add(4'b0000, 4'b0000, 4'd3, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add(4'b0000, 4'b0000, 4'd3, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add(4'b0000, 4'b0000, 4'd3, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0000, 4'b0000, 4'd3, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // ch1 re-request during HOLD with thresh=5
    add(4'b0010, 4'b0000, 4'd5, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 4'd5, 1'b0, 4'b0010, 4'b0000, 4'b0010);
    add(4'b0010, 4'b0000, 4'd5, 1'b0, 4'b0010, 4'b0010, 4'b0010);
    add(4'b0000, 4'b0000, 4'd5, 1'b0, 4'b0010, 4'b0010, 4'b0010);
    add(4'b0000, 4'b0000, 4'd5, 1'b0, 4'b0010, 4'b0010, 4'b0010);
    add(4'b0010, 4'b0000, 4'd5, 1'b0, 4'b0010, 4'b0010, 4'b0010);
    add(4'b0010, 4'b0000, 4'd5, 1'b0, 4'b0010, 4'b0010, 4'b0010);
    // want beats threshold in the same cycle, then thresh=1 release
    add(4'b0000, 4'b0000, 4'd1, 1'b0, 4'b0010, 4'b0010, 4'b0010);
    add(4'b0010, 4'b0000, 4'd1, 1'b0, 4'b0010, 4'b0010, 4'b0010);
    add(4'b0000, 4'b0000, 4'd1, 1'b0, 4'b0010, 4'b0010, 4'b0010);
    add(4'b0000, 4'b0000, 4'd1, 1'b0, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0000, 4'b0000, 4'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // ch2 with zero threshold
    add(4'b0100, 4'b0000, 4'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    add(4'b0100, 4'b0000, 4'd0, 1'b0, 4'b0100, 4'b0000, 4'b0100);
    add(4'b0100, 4'b0000, 4'd0, 1'b0, 4'b0100, 4'b0100, 4'b0100);
    add(4'b0000, 4'b0000, 4'd0, 1'b0, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 4'b0000, 4'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // ch2 force-on holds ON without a request
    add(4'b0000, 4'b0100, 4'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0100, 4'd0, 1'b0, 4'b0100, 4'b0000, 4'b0100);
    add(4'b0000, 4'b0100, 4'd0, 1'b0, 4'b0100, 4'b0100, 4'b0100);
    add(4'b0000, 4'b0100, 4'd0, 1'b0, 4'b0100, 4'b0100, 4'b0100);
    add(4'b0000, 4'b0100, 4'd0, 1'b0, 4'b0100, 4'b0100, 4'b0100);
    add(4'b0000, 4'b0000, 4'd0, 1'b0, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 4'b0000, 4'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // DFT override with all channels OFF
    add(4'b0000, 4'b0000, 4'd0, 1'b1, 4'b0000, 4'b0000, 4'b1111);
    add(4'b0000, 4'b0000, 4'd0, 1'b1, 4'b0000, 4'b0000, 4'b1111);
    add(4'b0000, 4'b0000, 4'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // ch0+ch3 together, then threshold lowered live during HOLD
    add(4'b1001, 4'b0000, 4'd2,  1'b0, 4'b1001, 4'b0000, 4'b0000);
    add(4'b1001, 4'b0000, 4'd2,  1'b0, 4'b1001, 4'b0000, 4'b1001);
    add(4'b1001, 4'b0000, 4'd2,  1'b0, 4'b1001, 4'b1001, 4'b1001);
    add(4'b0000, 4'b0000, 4'd15, 1'b0, 4'b1001, 4'b1001, 4'b1001);
    add(4'b0000, 4'b0000, 4'd15, 1'b0, 4'b1001, 4'b1001, 4'b1001);
    add(4'b0000, 4'b0000, 4'd1,  1'b0, 4'b0000, 4'b0000, 4'b1001);
    add(4'b0000, 4'b0000, 4'd1,  1'b0, 4'b0000, 4'b0000, 4'b0000);

    // reset held with all requests high and the clock running
    rst_n = 1'b0; test_en = 1'b0; ch_req = 4'b1111; ch_force_on = 4'b0000; idle_thresh = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset", i, 4'b0000, 4'b0000, 4'b0000);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    ch_req = 4'b0000;

    for (int i = 0; i < vt.size(); i++) begin
      ch_req = vt[i].req; ch_force_on = vt[i].frc; idle_thresh = vt[i].thr; test_en = vt[i].ten;
      tick();
      chk_all("vec", i, vt[i].act, vt[i].rdy, vt[i].g);
    end

    // reset asserted mid-wake on ch3 while its clock is high
    ch_req = 4'b1000; ch_force_on = 4'b0000; idle_thresh = 4'd3; test_en = 1'b0;
    tick();
    chk_all("mw_wake0", 0, 4'b1000, 4'b0000, 4'b0000);
    tick();
    chk_all("mw_wake1", 1, 4'b1000, 4'b0000, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk_all("mw_rst", 2, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("mw_re0", 3, 4'b1000, 4'b0000, 4'b0000);
    tick();
    chk_all("mw_re1", 4, 4'b1000, 4'b0000, 4'b1000);
    tick();
    chk_all("mw_re2", 5, 4'b1000, 4'b1000, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_ch_clk_gate_ctrl.md
# multi_ch_clk_gate_ctrl

Parametrised multi-channel clock-gating controller, successor to the single-channel latch-based ICG. It generates NUM_CH gated clocks from one root clock. Each channel has its own request-driven FSM with a programmable idle hysteresis before gating and a fixed wake-up delay before the channel is flagged ready. It sits between the system controller (request/force inputs) and the clock-domain consumers (ALU, register file, etc.) in the low-power clocking subsystem.

## Interface
- NUM_CH, 4, number of independent gated-clock channels (1..16)
- IDLE_CNT_W, 4, width of idle counter and idle_thresh
- WAKE_DLY, 2, cycles between enable assertion and ch_ready (1..7)
- CLK  input  1  root clock; all state updates on rising edge
- RST  input  1  asynchronous, active-low reset
- test_en  input  1  DFT override: all gated clocks free-run while high
- ch_req  input  NUM_CH  per-channel functional clock request
- ch_force_on  input  NUM_CH  per-channel software force-on; treated as a request
- idle_thresh  input  IDLE_CNT_W  shared idle-cycle threshold before gating
- gclk  output  NUM_CH  gated clocks, gclk[i] = CLK & latch_i
- ch_active  output  NUM_CH  registered gating enable per channel (en_q)
- ch_ready  output  NUM_CH  channel clock is stable and usable

## Operation
- Per channel: want = ch_req[i] | ch_force_on[i].
- Gating cell per channel: latch transparent while CLK low, D = en_q[i] | test_en; gclk[i] = CLK & latch_q. Glitch-free by construction. Latch is asynchronously cleared by RST.
- FSM states per channel:
  - OFF: en_q=0, ready=0. If want is high, go to WAKE and load wake_cnt=WAKE_DLY.
  - WAKE: en_q=1, ready=0. wake_cnt decrements each cycle. At wake_cnt==1, go to ON. want dropping in WAKE is ignored, and the wake always completes.
  - ON: en_q=1, ready=1. If want is low, go to HOLD with idle_cnt=0. If idle_thresh==0, go straight to OFF instead.
  - HOLD: en_q=1, ready=1. idle_cnt increments each cycle and saturates at all-ones. If want is high, go to ON and clear idle_cnt. If idle_cnt+1 >= idle_thresh, go to OFF.
- want has priority over the threshold when both occur in the same cycle (HOLD goes to ON).
- idle_thresh is sampled live. Lowering it during HOLD gates at the next edge where the >= compare is true.
- test_en affects only the latch D input. The FSM, ch_active and ch_ready run unchanged.
- Channels are fully independent. There is no shared arbitration.
- Reset (asynchronous assert, mid-operation included): all FSMs go to OFF, counters to 0, ch_active=0, ch_ready=0, latches cleared, so gclk=0 while RST is low. Outputs are clean from the first rising edge after deassertion.

## Timing
- Request latency: want sampled high at edge k gives en_q=1 after edge k, and the first gclk high phase at edge k+1.
- ch_ready rises after edge k+WAKE_DLY.
- Release latency: want low at edge m with thresh=T≥1 gives HOLD after m and OFF after edge m+T. The last gclk pulse is at edge m+T, with no pulse at m+T+1.
- Wake counter width is 3 bits. Idle counter width is IDLE_CNT_W, unsigned compare.
- ch_active and ch_ready are registered, with no combinational path from inputs.
- gclk has a combinational path from CLK only (one AND gate).

## Test plan
- Reset: hold RST=0 with ch_req=all-ones and CLK toggling. Expect gclk=0, ch_active=0, ch_ready=0. Release RST, then raise ch_req[0] at edge 3. Expect ch_active[0]=1 after edge 3, first gclk[0] pulse at edge 4, ch_ready[0]=1 after edge 5 (WAKE_DLY=2).
- Hysteresis: idle_thresh=3, ch0 in ON, drop ch_req[0] at edge 10. Expect gclk[0] pulses through edge 13, none from edge 14, ch_ready[0]=0 after edge 13.
- Re-request in HOLD: idle_thresh=5, drop ch_req[1] at edge 20, re-raise at edge 22. Expect the channel to return to ON with no gclk gap and ch_ready[1] held at 1 throughout.
- Zero threshold and force: idle_thresh=0, drop ch_req[2]. Expect gating one edge later. Then set ch_force_on[2]=1 with ch_req[2]=0. Expect a wake and ON held indefinitely.
- DFT: all channels OFF, set test_en=1. Expect every gclk to equal CLK from the next high phase, with ch_active and ch_ready remaining 0. Clear test_en and expect gclk to stop after the next low phase.
- Reset mid-wake: assert RST during WAKE on ch3. Expect gclk[3] low immediately and state OFF. After release, a new request requires the full WAKE_DLY again.
